// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and types for the register-write scoreboard.
package reg_scoreboard_pkg;
  localparam int SB_REGFILE_LEN = 6;
  localparam int SB_CNT_W       = 2;

  typedef logic [SB_REGFILE_LEN-1:0] reg_idx_t;

  localparam reg_idx_t             REG_ZERO   = '0;
  localparam logic [SB_CNT_W-1:0] SB_CNT_MAX = '1;
endpackage

// File: rtl/reg_scoreboard_if.sv
// Pipeline-control <-> scoreboard bundle: issue/retire/kill events,
// decode busy queries and status outputs.
interface reg_scoreboard_if
  import reg_scoreboard_pkg::*;
#(
  parameter int REGFILE_LEN = SB_REGFILE_LEN,
  parameter int CNT_W       = SB_CNT_W
);
  logic                         issue_valid;
  logic [REGFILE_LEN-1:0]       issue_rd;
  logic                         issue_ready;
  logic                         retire_valid;
  logic [REGFILE_LEN-1:0]       retire_rd;
  logic                         kill_valid;
  logic [REGFILE_LEN-1:0]       kill_rd;
  logic                         flush;
  logic [REGFILE_LEN-1:0]       rs1_q;
  logic [REGFILE_LEN-1:0]       rs2_q;
  logic                         rs1_busy;
  logic                         rs2_busy;
  logic [REGFILE_LEN+CNT_W-1:0] outstanding;
  logic                         empty;
  logic                         underflow_err;

  modport master (
    output issue_valid, issue_rd, retire_valid, retire_rd,
           kill_valid, kill_rd, flush, rs1_q, rs2_q,
    input  issue_ready, rs1_busy, rs2_busy, outstanding, empty, underflow_err
  );

  modport slave (
    input  issue_valid, issue_rd, retire_valid, retire_rd,
           kill_valid, kill_rd, flush, rs1_q, rs2_q,
    output issue_ready, rs1_busy, rs2_busy, outstanding, empty, underflow_err
  );
endinterface

// File: rtl/reg_scoreboard_counter.sv
// sb_counter: one saturating up/down outstanding-write counter.
// Up to one increment and two decrements per cycle; decrements that would
// go below zero clamp at 0 and raise a one-cycle underflow pulse.
// dec_eff reports how many decrements actually took effect so the parent
// can keep its running total exact.
module sb_counter
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec_a,
  input  logic             dec_b,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt,
  output logic             uflow,
  output logic [1:0]       dec_eff
);
  logic [CNT_W:0]   up;
  logic [1:0]       dec;
  logic [CNT_W-1:0] cnt_nxt;

  // Net update: +inc -dec_a -dec_b, clamp at zero; clear discards everything.
  always_comb begin
    up      = {1'b0, cnt} + (CNT_W+1)'(inc);
    dec     = {1'b0, dec_a} + {1'b0, dec_b};
    uflow   = 1'b0;
    dec_eff = dec;
    cnt_nxt = CNT_W'(up - (CNT_W+1)'(dec));
    if (clear) begin
      cnt_nxt = '0;
      dec_eff = '0;
    end else if (up < (CNT_W+1)'(dec)) begin
      cnt_nxt = '0;
      uflow   = 1'b1;
      dec_eff = up[1:0];
    end
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else      cnt <= cnt_nxt;
  end
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks in-flight register writes from ID to WB.
// One sb_counter per architectural register except x0. Busy queries see
// this cycle's retire/kill (write-first bypass) but not this cycle's issue.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int REGFILE_LEN = SB_REGFILE_LEN,
  parameter int CNT_W       = SB_CNT_W
) (
  input logic             clk,
  input logic             rst,
  reg_scoreboard_if.slave sb
);
  localparam int NREG  = 2**REGFILE_LEN;
  localparam int OUT_W = REGFILE_LEN + CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NREG-1:0][CNT_W-1:0] cnt;
  logic [NREG-1:1]            inc_oh, ret_oh, kil_oh, uflow;
  logic [NREG-1:1][1:0]       dec_eff;
  logic                       acc_i;
  logic [OUT_W-1:0]           dec_sum;
  logic [OUT_W-1:0]           outstanding_q;
  logic                       underflow_q;

  assign cnt[0] = '0;

  assign sb.issue_ready = (cnt[sb.issue_rd] != CNT_MAX);
  assign acc_i          = sb.issue_valid & sb.issue_ready & (sb.issue_rd != '0);

  // Decode event register indices into per-counter enables.
  always_comb begin
    inc_oh = '0;
    ret_oh = '0;
    kil_oh = '0;
    for (int i = 1; i < NREG; i++) begin
      inc_oh[i] = acc_i           && (sb.issue_rd  == REGFILE_LEN'(i));
      ret_oh[i] = sb.retire_valid && (sb.retire_rd == REGFILE_LEN'(i));
      kil_oh[i] = sb.kill_valid   && (sb.kill_rd   == REGFILE_LEN'(i));
    end
  end

  for (genvar g = 1; g < NREG; g++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (inc_oh[g]),
      .dec_a   (ret_oh[g]),
      .dec_b   (kil_oh[g]),
      .clear   (sb.flush),
      .cnt     (cnt[g]),
      .uflow   (uflow[g]),
      .dec_eff (dec_eff[g])
    );
  end

  // Busy = pre-edge count minus this cycle's retire/kill on that index.
  function automatic logic busy_of(input logic [REGFILE_LEN-1:0] rs);
    int dec;
    dec = int'(sb.retire_valid && (sb.retire_rd == rs))
        + int'(sb.kill_valid   && (sb.kill_rd   == rs));
    return (rs != '0) && (int'(cnt[rs]) > dec);
  endfunction

  assign sb.rs1_busy = busy_of(sb.rs1_q);
  assign sb.rs2_busy = busy_of(sb.rs2_q);

  // Sum of decrements that really landed (clamped ones excluded).
  always_comb begin
    dec_sum = '0;
    for (int i = 1; i < NREG; i++) dec_sum = dec_sum + OUT_W'(dec_eff[i]);
  end

  // Running total of outstanding writes and sticky underflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding_q <= '0;
      underflow_q   <= 1'b0;
    end else begin
      outstanding_q <= sb.flush ? '0 : outstanding_q + OUT_W'(acc_i) - dec_sum;
      underflow_q   <= underflow_q | (|uflow);
    end
  end

  assign sb.outstanding   = outstanding_q;
  assign sb.empty         = (outstanding_q == '0);
  assign sb.underflow_err = underflow_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: one task per scenario, inline checks.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   ncmp = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  reg_scoreboard_if #(.REGFILE_LEN(SB_REGFILE_LEN), .CNT_W(SB_CNT_W)) sb ();

  reg_scoreboard #(.REGFILE_LEN(SB_REGFILE_LEN), .CNT_W(SB_CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb)
  );

  task automatic idle();
    sb.issue_valid  = 1'b0; sb.issue_rd  = '0;
    sb.retire_valid = 1'b0; sb.retire_rd = '0;
    sb.kill_valid   = 1'b0; sb.kill_rd   = '0;
    sb.flush        = 1'b0;
    sb.rs1_q        = '0;   sb.rs2_q     = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input int rd);
    idle(); sb.issue_valid = 1'b1; sb.issue_rd = reg_idx_t'(rd); step(); idle();
  endtask

  task automatic retire(input int rd);
    idle(); sb.retire_valid = 1'b1; sb.retire_rd = reg_idx_t'(rd); step(); idle();
  endtask

  task automatic test_reset();
    rst = 1'b0; idle(); #2;
    ncmp++; if (sb.empty !== 1'b1) begin nerr++; $display("FAIL rst_empty got %b want 1", sb.empty); end
    ncmp++; if (sb.outstanding !== 8'd0) begin nerr++; $display("FAIL rst_out got %0d want 0", sb.outstanding); end
    ncmp++; if (sb.underflow_err !== 1'b0) begin nerr++; $display("FAIL rst_uf got %b want 0", sb.underflow_err); end
    ncmp++; if (sb.issue_ready !== 1'b1) begin nerr++; $display("FAIL rst_ready got %b want 1", sb.issue_ready); end
    rst = 1'b1;
    step();
    issue(7); issue(7);
    sb.rs1_q = 6'd7; sb.issue_rd = 6'd7; #1;
    ncmp++; if (sb.rs1_busy !== 1'b1) begin nerr++; $display("FAIL pre_rst_busy7 got %b want 1", sb.rs1_busy); end
    ncmp++; if (sb.outstanding !== 8'd2) begin nerr++; $display("FAIL pre_rst_out got %0d want 2", sb.outstanding); end
    rst = 1'b0; #1;
    ncmp++; if (sb.empty !== 1'b1) begin nerr++; $display("FAIL midrst_empty got %b want 1", sb.empty); end
    ncmp++; if (sb.rs1_busy !== 1'b0) begin nerr++; $display("FAIL midrst_busy7 got %b want 0", sb.rs1_busy); end
    ncmp++; if (sb.outstanding !== 8'd0) begin nerr++; $display("FAIL midrst_out got %0d want 0", sb.outstanding); end
    ncmp++; if (sb.issue_ready !== 1'b1) begin nerr++; $display("FAIL midrst_ready got %b want 1", sb.issue_ready); end
    rst = 1'b1; idle(); step();
  endtask

  task automatic test_issue_retire();
    idle(); sb.issue_valid = 1'b1; sb.issue_rd = 6'd5; sb.rs1_q = 6'd5; #1;
    ncmp++; if (sb.rs1_busy !== 1'b0) begin nerr++; $display("FAIL ir_issue_nobypass got %b want 0", sb.rs1_busy); end
    step(); idle(); sb.rs1_q = 6'd5; #1;
    ncmp++; if (sb.rs1_busy !== 1'b1) begin nerr++; $display("FAIL ir_busy5 got %b want 1", sb.rs1_busy); end
    ncmp++; if (sb.outstanding !== 8'd1) begin nerr++; $display("FAIL ir_out1 got %0d want 1", sb.outstanding); end
    ncmp++; if (sb.empty !== 1'b0) begin nerr++; $display("FAIL ir_empty0 got %b want 0", sb.empty); end
    sb.retire_valid = 1'b1; sb.retire_rd = 6'd5; #1;
    ncmp++; if (sb.rs1_busy !== 1'b0) begin nerr++; $display("FAIL ir_retire_bypass got %b want 0", sb.rs1_busy); end
    step(); idle();
    ncmp++; if (sb.outstanding !== 8'd0) begin nerr++; $display("FAIL ir_out0 got %0d want 0", sb.outstanding); end
    ncmp++; if (sb.empty !== 1'b1) begin nerr++; $display("FAIL ir_empty1 got %b want 1", sb.empty); end
  endtask

  task automatic test_saturation();
    issue(3); issue(3); issue(3);
    sb.issue_rd = 6'd3; #1;
    ncmp++; if (sb.issue_ready !== 1'b0) begin nerr++; $display("FAIL sat_ready got %b want 0", sb.issue_ready); end
    ncmp++; if (sb.outstanding !== 8'd3) begin nerr++; $display("FAIL sat_out3 got %0d want 3", sb.outstanding); end
    issue(3);
    ncmp++; if (sb.outstanding !== 8'd3) begin nerr++; $display("FAIL sat_4th_ignored got %0d want 3", sb.outstanding); end
    idle(); sb.issue_valid = 1'b1; sb.issue_rd = 6'd3; sb.retire_valid = 1'b1; sb.retire_rd = 6'd3; #1;
    ncmp++; if (sb.issue_ready !== 1'b0) begin nerr++; $display("FAIL sat_ready_w_retire got %b want 0", sb.issue_ready); end
    step(); idle();
    ncmp++; if (sb.outstanding !== 8'd2) begin nerr++; $display("FAIL sat_issue_refused got %0d want 2", sb.outstanding); end
    retire(3); retire(3);
    ncmp++; if (sb.outstanding !== 8'd0) begin nerr++; $display("FAIL sat_drain got %0d want 0", sb.outstanding); end
  endtask

  task automatic test_simultaneous();
    issue(9); issue(9);
    idle(); sb.issue_valid = 1'b1; sb.issue_rd = 6'd9; sb.retire_valid = 1'b1; sb.retire_rd = 6'd9;
    sb.rs2_q = 6'd9; #1;
    ncmp++; if (sb.rs2_busy !== 1'b1) begin nerr++; $display("FAIL sim_busy_2m1 got %b want 1", sb.rs2_busy); end
    step(); idle();
    ncmp++; if (sb.outstanding !== 8'd2) begin nerr++; $display("FAIL sim_net0 got %0d want 2", sb.outstanding); end
    sb.retire_valid = 1'b1; sb.retire_rd = 6'd9; sb.kill_valid = 1'b1; sb.kill_rd = 6'd9; sb.rs2_q = 6'd9; #1;
    ncmp++; if (sb.rs2_busy !== 1'b0) begin nerr++; $display("FAIL sim_dec2_bypass got %b want 0", sb.rs2_busy); end
    step(); idle(); sb.rs2_q = 6'd9; #1;
    ncmp++; if (sb.outstanding !== 8'd0) begin nerr++; $display("FAIL sim_dec2_out got %0d want 0", sb.outstanding); end
    ncmp++; if (sb.rs2_busy !== 1'b0) begin nerr++; $display("FAIL sim_busy9_after got %b want 0", sb.rs2_busy); end
    ncmp++; if (sb.underflow_err !== 1'b0) begin nerr++; $display("FAIL sim_no_uf got %b want 0", sb.underflow_err); end
    issue(12);
    idle(); sb.kill_valid = 1'b1; sb.kill_rd = 6'd12; step(); idle();
    ncmp++; if (sb.outstanding !== 8'd0) begin nerr++; $display("FAIL sim_kill_out got %0d want 0", sb.outstanding); end
  endtask

  task automatic test_flush();
    issue(4); issue(6); issue(6);
    ncmp++; if (sb.outstanding !== 8'd3) begin nerr++; $display("FAIL fl_pre_out got %0d want 3", sb.outstanding); end
    idle(); sb.flush = 1'b1; sb.issue_valid = 1'b1; sb.issue_rd = 6'd8;
    sb.retire_valid = 1'b1; sb.retire_rd = 6'd4; sb.rs1_q = 6'd4; sb.rs2_q = 6'd6; #1;
    ncmp++; if (sb.rs1_busy !== 1'b0) begin nerr++; $display("FAIL fl_busy4 got %b want 0", sb.rs1_busy); end
    ncmp++; if (sb.rs2_busy !== 1'b1) begin nerr++; $display("FAIL fl_busy6_nobypass got %b want 1", sb.rs2_busy); end
    step(); idle(); sb.rs1_q = 6'd8; sb.rs2_q = 6'd6; #1;
    ncmp++; if (sb.outstanding !== 8'd0) begin nerr++; $display("FAIL fl_out got %0d want 0", sb.outstanding); end
    ncmp++; if (sb.empty !== 1'b1) begin nerr++; $display("FAIL fl_empty got %b want 1", sb.empty); end
    ncmp++; if (sb.rs1_busy !== 1'b0) begin nerr++; $display("FAIL fl_busy8 got %b want 0", sb.rs1_busy); end
    ncmp++; if (sb.rs2_busy !== 1'b0) begin nerr++; $display("FAIL fl_busy6 got %b want 0", sb.rs2_busy); end
    ncmp++; if (sb.underflow_err !== 1'b0) begin nerr++; $display("FAIL fl_uf got %b want 0", sb.underflow_err); end
  endtask

  task automatic test_reg0_underflow();
    idle(); sb.issue_valid = 1'b1; sb.issue_rd = 6'd0; sb.rs1_q = 6'd0; #1;
    ncmp++; if (sb.issue_ready !== 1'b1) begin nerr++; $display("FAIL r0_ready got %b want 1", sb.issue_ready); end
    step(); idle(); sb.rs1_q = 6'd0; #1;
    ncmp++; if (sb.outstanding !== 8'd0) begin nerr++; $display("FAIL r0_out got %0d want 0", sb.outstanding); end
    ncmp++; if (sb.rs1_busy !== 1'b0) begin nerr++; $display("FAIL r0_busy got %b want 0", sb.rs1_busy); end
    idle(); sb.retire_valid = 1'b1; sb.kill_valid = 1'b1; step(); idle();
    ncmp++; if (sb.underflow_err !== 1'b0) begin nerr++; $display("FAIL r0_dec_ignored got %b want 0", sb.underflow_err); end
    retire(11);
    ncmp++; if (sb.underflow_err !== 1'b1) begin nerr++; $display("FAIL uf_set got %b want 1", sb.underflow_err); end
    ncmp++; if (sb.outstanding !== 8'd0) begin nerr++; $display("FAIL uf_out got %0d want 0", sb.outstanding); end
    idle(); sb.flush = 1'b1; step(); idle(); step();
    ncmp++; if (sb.underflow_err !== 1'b1) begin nerr++; $display("FAIL uf_sticky got %b want 1", sb.underflow_err); end
  endtask

  initial begin
    test_reset();
    test_issue_retire();
    test_saturation();
    test_simultaneous();
    test_flush();
    test_reg0_underflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
